// File: rtl/adc_media_movel.sv
`default_nettype none
// ============================================================================
// Module   : adc_media_movel
// Brief    : Boxcar moving average over 2^LOG2_N ADC samples with a
//            hysteresis threshold flag on the filtered reading.
// Revision : 1.0 - initial release
// ============================================================================
module adc_media_movel #(
    parameter int DATA_W = 12,
    parameter int LOG2_N = 3,
    parameter int HYST   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              flush,
    input  logic [DATA_W-1:0] thr_level,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    output logic              above_thr,
    output logic              filled
);

    localparam int                  c_n        = 1 << LOG2_N;
    localparam int                  c_sum_w    = DATA_W + LOG2_N;
    localparam int                  c_lvl_w    = DATA_W + 2;
    localparam logic [LOG2_N:0]     c_cnt_last = (LOG2_N + 1)'(c_n - 1);
    localparam logic [LOG2_N:0]     c_cnt_full = (LOG2_N + 1)'(c_n);
    localparam logic [c_lvl_w-1:0]  c_hyst     = c_lvl_w'(HYST);
    localparam logic [c_lvl_w-1:0]  c_max      = {2'b00, {DATA_W{1'b1}}};

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_buf [c_n];
    logic [LOG2_N-1:0]   r_wr_ptr;
    logic [LOG2_N:0]     r_count;
    logic [c_sum_w-1:0]  r_sum;
    logic [DATA_W-1:0]   r_avg;
    logic                r_avg_valid;
    logic                r_above;
    logic                r_filled;

    logic                w_accept;
    logic                w_last_fill;
    logic                w_emit;
    logic [DATA_W-1:0]   w_old;
    logic [c_sum_w-1:0]  w_sum_nxt;
    logic [DATA_W-1:0]   w_avg_nxt;
    logic [c_lvl_w-1:0]  w_thr_wide;
    logic [c_lvl_w-1:0]  w_set_raw;
    logic [c_lvl_w-1:0]  w_set_lvl;
    logic [c_lvl_w-1:0]  w_clr_lvl;
    logic [c_lvl_w-1:0]  w_avg_wide;
    logic                w_above_nxt;

    // Evicted value is masked until the window has been filled once, so the
    // stale buffer contents never need clearing.
    always_comb begin
        w_accept    = sample_valid & ~flush;
        w_last_fill = (r_state == S_FILL) && (r_count == c_cnt_last);
        w_emit      = w_accept && ((r_state == S_RUN) || w_last_fill);
        w_old       = (r_state == S_RUN) ? r_buf[r_wr_ptr] : '0;
        w_sum_nxt   = r_sum + c_sum_w'(sample_in) - c_sum_w'(w_old);
        w_avg_nxt   = w_sum_nxt[c_sum_w-1 -: DATA_W];
    end

    // Levels are computed two bits wider so thr_level +/- HYST cannot wrap.
    always_comb begin
        w_thr_wide = c_lvl_w'(thr_level);
        w_set_raw  = w_thr_wide + c_hyst;
        w_set_lvl  = (w_set_raw > c_max) ? c_max : w_set_raw;
        w_clr_lvl  = (w_thr_wide >= c_hyst) ? (w_thr_wide - c_hyst) : '0;
        w_avg_wide = c_lvl_w'(w_avg_nxt);
        w_above_nxt = r_above;
        if (w_avg_wide >= w_set_lvl) begin
            w_above_nxt = 1'b1;
        end else if (w_avg_wide < w_clr_lvl) begin
            w_above_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_FILL;
        end else if (w_accept && w_last_fill) begin
            w_state_nxt = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            r_buf[r_wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum       <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            r_above     <= 1'b0;
            r_filled    <= 1'b0;
        end else if (flush) begin
            r_sum       <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_avg_valid <= 1'b0;
            r_above     <= 1'b0;
            r_filled    <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
            if (w_accept) begin
                r_sum    <= w_sum_nxt;
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_state == S_FILL) begin
                    r_count <= w_last_fill ? c_cnt_full : r_count + 1'b1;
                end
                if (w_last_fill) begin
                    r_filled <= 1'b1;
                end
                if (w_emit) begin
                    r_avg       <= w_avg_nxt;
                    r_avg_valid <= 1'b1;
                    r_above     <= w_above_nxt;
                end
            end
        end
    end

    assign avg_out   = r_avg;
    assign avg_valid = r_avg_valid;
    assign above_thr = r_above;
    assign filled    = r_filled;

endmodule
`default_nettype wire

// File: tb/tb_adc_media_movel.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_media_movel
// Brief    : Directed scoreboard bench for the moving-average filter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_media_movel;

    logic        clk;
    logic        reset;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic        flush;
    logic [11:0] thr_level;
    logic [11:0] avg_out;
    logic        avg_valid;
    logic        above_thr;
    logic        filled;

    int errors;
    int checks;

    int exp_avg_q [$];
    bit exp_flag_q [$];

    int hy_b [8] = '{2015, 2015, 2015, 2015, 2015, 2015, 2015, 2016};
    int hy_c [8] = '{2012, 2008, 2004, 2000, 1996, 1992, 1988, 1985};
    int low_z [8] = '{22, 19, 16, 13, 9, 6, 3, 0};
    int step_v [8] = '{511, 1023, 1535, 2047, 2559, 3071, 3583, 4095};

    adc_media_movel #(
        .DATA_W (12),
        .LOG2_N (3),
        .HYST   (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .flush        (flush),
        .thr_level    (thr_level),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid),
        .above_thr    (above_thr),
        .filled       (filled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Monitor: every avg_valid pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (avg_valid) begin
            checks++;
            if (exp_avg_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_avg_valid: got avg_out=%0d, expected no output", avg_out);
            end else begin
                int ea;
                bit ef;
                ea = exp_avg_q.pop_front();
                ef = exp_flag_q.pop_front();
                if (avg_out !== 12'(ea) || above_thr !== ef) begin
                    errors++;
                    $display("FAIL avg_update: got avg=%0d above=%0b, expected avg=%0d above=%0b",
                             avg_out, above_thr, ea, ef);
                end
            end
        end
    end

    task automatic push(input int a, input bit f);
        exp_avg_q.push_back(a);
        exp_flag_q.push_back(f);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic strobe(input int val, input int gap);
        sample_in    = 12'(val);
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic settle();
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset        = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        flush        = 1'b0;
        thr_level    = 12'd2000;
        @(posedge clk); #1;
        do_reset();
        check("reset_avg_out", int'(avg_out), 0);
        check("reset_avg_valid", int'(avg_valid), 0);
        check("reset_above", int'(above_thr), 0);
        check("reset_filled", int'(filled), 0);

        // Fill: eight spaced strobes of 800, output only after the 8th.
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) push(800, 1'b0);
            strobe(800, 0);
            check($sformatf("fill_filled_%0d", i), int'(filled), (i == 8) ? 1 : 0);
            repeat (2) begin
                @(posedge clk); #1;
            end
        end
        check("fill_filled_held", int'(filled), 1);

        // Flush with a coincident sample: sample dropped, avg_out held.
        thr_level = 12'd500;
        push(800, 1'b1);
        strobe(800, 1);
        check("pre_flush_above", int'(above_thr), 1);
        sample_in    = 12'd4000;
        sample_valid = 1'b1;
        flush        = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        flush        = 1'b0;
        check("flush_filled", int'(filled), 0);
        check("flush_above", int'(above_thr), 0);
        check("flush_avg_hold", int'(avg_out), 800);
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) push(100, 1'b0);
            strobe(100, 0);
            if (i == 7) begin
                check("flush_refill_filled_7", int'(filled), 0);
                check("flush_refill_avg_7", int'(avg_out), 800);
            end
        end
        settle();

        // Hysteresis around thr_level=2000 (set 2016, clear below 1984).
        thr_level = 12'd2000;
        do_flush();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) push(2015, 1'b0);
            strobe(2015, 0);
        end
        for (int i = 0; i < 8; i++) begin
            push(hy_b[i], (i == 7));
            strobe(2016, 0);
        end
        for (int i = 0; i < 8; i++) begin
            push(hy_c[i], 1'b1);
            strobe(1985, 0);
        end
        for (int i = 0; i < 8; i++) begin
            push(1984, 1'b1);
            strobe(1984, 0);
        end
        for (int i = 0; i < 8; i++) begin
            push(1983, 1'b0);
            strobe(1983, 0);
        end
        settle();

        // Low threshold: clear level is 0, so the flag never clears.
        thr_level = 12'd10;
        do_flush();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) push(26, 1'b1);
            strobe(26, 0);
        end
        for (int i = 0; i < 8; i++) begin
            push(low_z[i], 1'b1);
            strobe(0, 0);
        end
        settle();

        // Step response from a window of zeros.
        thr_level = 12'd2000;
        do_flush();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) push(0, 1'b0);
            strobe(0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            push(step_v[i], (i >= 3));
            strobe(4095, 1);
        end
        settle();

        // Back-to-back ramp 0..19.
        thr_level = 12'd4000;
        do_flush();
        for (int k = 0; k < 20; k++) begin
            if (k >= 7) push(k - 4, 1'b0);
            sample_in    = 12'(k);
            sample_valid = 1'b1;
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        settle();
        check("ramp_final", int'(avg_out), 15);

        // Reset mid-fill discards partial state.
        thr_level = 12'd500;
        do_flush();
        for (int i = 0; i < 5; i++) strobe(3000, 0);
        do_reset();
        check("midreset_avg_out", int'(avg_out), 0);
        check("midreset_avg_valid", int'(avg_valid), 0);
        check("midreset_above", int'(above_thr), 0);
        check("midreset_filled", int'(filled), 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) push(1234, 1'b1);
            strobe(1234, 0);
        end
        settle();

        check("scoreboard_drained", exp_avg_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
